// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared state encodings, flag indices and default widths for
//               the CPU control register stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int DEF_STATE_W    = 8;
    localparam int DEF_INSTR_W    = 16;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_WDOG_LIMIT = 64;

    localparam logic [7:0] S_FETCH  = 8'h00;
    localparam logic [7:0] S_DECODE = 8'h01;
    localparam logic [7:0] S_WAIT   = 8'h0F;

    localparam int FLAG_N = 3;
    localparam int FLAG_P = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    // Never returns zero so a degenerate limit still yields a legal counter.
    function automatic int wdog_cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/state_watchdog.sv
// ============================================================================
// Module      : state_watchdog
// Description : Counts consecutive busy (non-fetch) cycles and requests a
//               forced return to fetch when the limit is reached; sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module state_watchdog
    import cpu_ctrl_pkg::*;
#(
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic clk,
    input  logic reset,
    input  logic state_busy,
    output logic force_fetch,
    output logic fault
);

    localparam int c_CNT_W = wdog_cnt_w(WDOG_LIMIT);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WDOG_LIMIT - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_fault;

    // state_busy comes from the state register, so this stays registered-only.
    assign force_fetch = state_busy && (r_cnt == c_LAST);
    assign fault       = r_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_fault <= 1'b0;
        end else if (!state_busy || force_fetch) begin
            r_cnt <= '0;
            if (force_fetch) begin
                r_fault <= 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control_regs.sv
// ============================================================================
// Module      : cpu_control_regs
// Description : State, instruction and status registers plus retire counter
//               downstream of the next-state decoder. Optional watchdog is
//               built when CPU_STATE_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_regs
    import cpu_ctrl_pkg::*;
#(
    parameter int STATE_W    = DEF_STATE_W,
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int WDOG_LIMIT = DEF_WDOG_LIMIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] next_state,
    input  logic               stall,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic [3:0]         alu_flags,
    input  logic               flags_we,
    output logic [STATE_W-1:0] state,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         status_reg,
    output logic               retire,
    output logic [CNT_W-1:0]   retired_count,
    output logic               wdog_fault
);

    localparam logic [STATE_W-1:0] c_FETCH = STATE_W'(S_FETCH);
    localparam logic [STATE_W-1:0] c_WAIT  = STATE_W'(S_WAIT);

    logic [STATE_W-1:0] r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [3:0]         r_status;
    logic               r_retire;
    logic [CNT_W-1:0]   r_count;

    logic w_busy;
    logic w_force_fetch;
    logic w_fault;
    logic w_retire_cond;

    assign w_busy        = (r_state != c_FETCH);
    assign w_retire_cond = w_busy && (next_state == c_FETCH) && !stall && !w_force_fetch;

`ifdef CPU_STATE_WATCHDOG_EN
    state_watchdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_state_watchdog (
        .clk         (clk),
        .reset       (reset),
        .state_busy  (w_busy),
        .force_fetch (w_force_fetch),
        .fault       (w_fault)
    );
`else
    logic w_unused_wdog_limit;
    assign w_unused_wdog_limit = (WDOG_LIMIT > 0);
    assign w_force_fetch       = 1'b0;
    assign w_fault             = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_FETCH;
            r_instr  <= '0;
            r_status <= '0;
            r_retire <= 1'b0;
            r_count  <= '0;
        end else begin
            r_retire <= w_retire_cond;
            if (w_retire_cond) begin
                r_count <= r_count + 1'b1;
            end
            if (!stall) begin
                if (r_state == c_WAIT) begin
                    r_instr <= mem_rdata;
                end
                if (flags_we) begin
                    r_status <= alu_flags;
                end
            end
            // Watchdog recovery overrides a stall.
            if (w_force_fetch) begin
                r_state <= c_FETCH;
            end else if (!stall) begin
                r_state <= next_state;
            end
        end
    end

    assign state         = r_state;
    assign instr         = r_instr;
    assign status_reg    = r_status;
    assign retire        = r_retire;
    assign retired_count = r_count;
    assign wdog_fault    = w_fault;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_regs.sv
// ============================================================================
// Module      : tb_cpu_control_regs
// Description : Directed scoreboard bench for cpu_control_regs; watchdog
//               expectations follow CPU_STATE_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_regs;

    logic        clk;
    logic        reset;
    logic [7:0]  next_state;
    logic        stall;
    logic [15:0] mem_rdata;
    logic [3:0]  alu_flags;
    logic        flags_we;
    logic [7:0]  state;
    logic [15:0] instr;
    logic [3:0]  status_reg;
    logic        retire;
    logic [15:0] retired_count;
    logic        wdog_fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    cpu_control_regs #(
        .STATE_W    (8),
        .INSTR_W    (16),
        .CNT_W      (16),
        .WDOG_LIMIT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .next_state    (next_state),
        .stall         (stall),
        .mem_rdata     (mem_rdata),
        .alu_flags     (alu_flags),
        .flags_we      (flags_we),
        .state         (state),
        .instr         (instr),
        .status_reg    (status_reg),
        .retire        (retire),
        .retired_count (retired_count),
        .wdog_fault    (wdog_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b1;
        next_state = 8'h00;
        stall      = 1'b0;
        mem_rdata  = 16'h0000;
        alu_flags  = 4'h0;
        flags_we   = 1'b0;
        #12;

        push("rst_state", 0); push("rst_instr", 0); push("rst_status", 0);
        push("rst_retire", 0); push("rst_count", 0); push("rst_wdog", 0);
        pop_chk(state); pop_chk(instr); pop_chk(status_reg);
        pop_chk(retire); pop_chk(retired_count); pop_chk(wdog_fault);

        // Fetch sequence 00 -> 0F -> 01
        @(negedge clk);
        reset = 1'b0;
        next_state = 8'h0F;
        push("fetch_state", 8'h0F); push("fetch_retire", 0);
        step();
        pop_chk(state); pop_chk(retire);

        mem_rdata = 16'h1234; next_state = 8'h01;
        push("decode_state", 8'h01); push("decode_instr", 16'h1234); push("decode_retire", 0);
        step();
        pop_chk(state); pop_chk(instr); pop_chk(retire);

        // Stall while waiting on memory
        next_state = 8'h0F;
        push("wait_state", 8'h0F); push("wait_instr", 16'h1234);
        step();
        pop_chk(state); pop_chk(instr);

        stall = 1'b1; next_state = 8'h01;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = (i == 0) ? 16'hAAAA : 16'h5555;
            push("stall_state", 8'h0F); push("stall_instr", 16'h1234);
            step();
            pop_chk(state); pop_chk(instr);
        end

        stall = 1'b0; mem_rdata = 16'h5555;
        push("unstall_state", 8'h01); push("unstall_instr", 16'h5555);
        step();
        pop_chk(state); pop_chk(instr);

        // Status register writes
        flags_we = 1'b1; alu_flags = 4'b0010;
        push("flags_write", 4'b0010);
        step();
        pop_chk(status_reg);

        stall = 1'b1; alu_flags = 4'b1101;
        push("flags_stalled", 4'b0010); push("flags_stall_state", 8'h01);
        step();
        pop_chk(status_reg); pop_chk(state);
        stall = 1'b0; flags_we = 1'b0;

        // Counter wrap on a MOV 01 -> 03 -> 00
        force dut.r_count = 16'hFFFF;
        #1;
        release dut.r_count;
        next_state = 8'h03;
        push("mov_state", 8'h03); push("mov_retire", 0); push("mov_count", 16'hFFFF);
        step();
        pop_chk(state); pop_chk(retire); pop_chk(retired_count);

        next_state = 8'h00;
        push("wrap_retire", 1); push("wrap_count", 16'h0000); push("wrap_state", 8'h00);
        step();
        pop_chk(retire); pop_chk(retired_count); pop_chk(state);

        next_state = 8'h0F;
        push("pulse_end", 0); push("pulse_end_count", 0);
        step();
        pop_chk(retire); pop_chk(retired_count);

        // Undecoded state falling back to fetch still retires
        next_state = 8'h4A;
        push("undec_retire", 0);
        step();
        pop_chk(retire);
        next_state = 8'h00;
        push("undec_retire2", 1); push("undec_count", 1);
        step();
        pop_chk(retire); pop_chk(retired_count);

        // Asynchronous reset in the middle of an ADD
        next_state = 8'h0A;
        flags_we = 1'b1; alu_flags = 4'b1001;
        step();
        flags_we = 1'b0;
        push("add_state", 8'h0A);
        pop_chk(state);
        next_state = 8'h00;
        #2;
        reset = 1'b1;
        #1;
        push("arst_state", 0); push("arst_instr", 0); push("arst_status", 0);
        push("arst_retire", 0); push("arst_count", 0); push("arst_wdog", 0);
        pop_chk(state); pop_chk(instr); pop_chk(status_reg);
        pop_chk(retire); pop_chk(retired_count); pop_chk(wdog_fault);
        @(negedge clk);
        reset = 1'b0;
        push("post_rst_retire", 0); push("post_rst_count", 0);
        step();
        pop_chk(retire); pop_chk(retired_count);

        // Hung loop in state 0x10
        next_state = 8'h10;
        push("loop_enter", 8'h10);
        step();
        pop_chk(state);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        push("loop_hold", 8'h10); push("loop_hold_wdog", 0);
        pop_chk(state); pop_chk(wdog_fault);
        step();
`ifdef CPU_STATE_WATCHDOG_EN
        push("wdog_state", 8'h00); push("wdog_fault", 1);
`else
        push("wdog_state", 8'h10); push("wdog_fault", 0);
`endif
        push("wdog_retire", 0); push("wdog_count", 0);
        pop_chk(state); pop_chk(wdog_fault); pop_chk(retire); pop_chk(retired_count);

        next_state = 8'h00;
        step();
`ifdef CPU_STATE_WATCHDOG_EN
        push("wdog_sticky", 1); push("wdog_sticky_count", 0);
`else
        push("wdog_sticky", 0); push("wdog_sticky_count", 1);
`endif
        pop_chk(wdog_fault); pop_chk(retired_count);

        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
